hv_adc_avg_mc: RTL

HV_ADC_AVG_MC -- requirements
Module: hv_adc_avg_mc

---
 rtl/hv_adc_avg_mc.sv | 96 +++++++++
 1 files changed

// File: rtl/hv_adc_avg_mc.sv
// hv_adc_avg_mc: per-channel sliding-window ADC averager; HV_ADC_AVG_OVTH_EN adds over-threshold flags
module hv_adc_avg_mc #(
  parameter int CH_NUM = 2,
  parameter int ADC_DW = 10,
  parameter int MAX_WIN_LOG2 = 3,
  localparam int WW = $clog2(MAX_WIN_LOG2 + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [CH_NUM-1:0]              i_adc_rdy,
  input  logic [CH_NUM-1:0][ADC_DW-1:0]  i_adc_data,
  input  logic [WW-1:0]                  i_avg_win,
  output logic [CH_NUM-1:0]              o_avg_vld,
  output logic [CH_NUM-1:0][ADC_DW-1:0]  o_avg_data
`ifdef HV_ADC_AVG_OVTH_EN
  ,
  input  logic [ADC_DW-1:0]              i_thresh,
  output logic [CH_NUM-1:0]              o_ovth
`endif
);
  localparam int DEPTH = 1 << MAX_WIN_LOG2;
  localparam int SW = ADC_DW + MAX_WIN_LOG2;
  logic [CH_NUM-1:0] sync1, sync2, sync_d;
  logic [WW-1:0] win_in, win_r;
  logic [MAX_WIN_LOG2:0] n;
  logic flush;
  always_comb begin
    win_in = (i_avg_win > WW'(MAX_WIN_LOG2)) ? WW'(MAX_WIN_LOG2) : i_avg_win;
    n = (MAX_WIN_LOG2 + 1)'(1) << win_r;
    flush = win_in != win_r;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync_d <= '0;
      win_r <= '0;
    end else begin
      sync1 <= i_adc_rdy;
      sync2 <= sync1;
      sync_d <= sync2;
      win_r <= win_in;
    end
  end
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [ADC_DW-1:0] mem [DEPTH];
    logic [MAX_WIN_LOG2-1:0] ptr;
    logic [MAX_WIN_LOG2:0] fill, fill_nx;
    logic [SW-1:0] sum, sum_nx;
    logic [ADC_DW-1:0] oldest, avg, avg_q;
    logic cap, pend, vld_q;
    always_comb begin
      cap = sync2[c] & ~sync_d[c] & ~flush;
      oldest = (fill == n) ? mem[ptr - n[MAX_WIN_LOG2-1:0]] : '0;
      fill_nx = (fill == n) ? fill : fill + 1'b1;
      sum_nx = sum + SW'(i_adc_data[c]) - SW'(oldest);
      avg = ADC_DW'(sum >> win_r);
    end
    // pend marks cycle C+1 of a capture that completed a window
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        ptr <= '0;
        fill <= '0;
        sum <= '0;
        pend <= 1'b0;
        vld_q <= 1'b0;
        avg_q <= '0;
      end else begin
        if (flush) begin
          ptr <= '0;
          fill <= '0;
          sum <= '0;
        end else if (cap) begin
          mem[ptr] <= i_adc_data[c];
          ptr <= ptr + 1'b1;
          fill <= fill_nx;
          sum <= sum_nx;
        end
        pend <= cap && (fill_nx == n);
        vld_q <= pend;
        if (pend) avg_q <= avg;
      end
    end
    assign o_avg_vld[c] = vld_q;
    assign o_avg_data[c] = avg_q;
`ifdef HV_ADC_AVG_OVTH_EN
    logic ovth_q;
    always_ff @(posedge i_clk) begin
      if (i_rst) ovth_q <= 1'b0;
      else if (pend) ovth_q <= avg > i_thresh;
    end
    assign o_ovth[c] = ovth_q;
`endif
  end
endmodule
